systolic_array_ws: RTL and testbench

- Parametrised ROWS x COLS weight-stationary systolic array built from a MAC grid.
- Includes a weight-load sequencer, input skew registers, output de-skew registers, and valid/ready handshakes.
- Computes one result vector per accepted activation vector: out[j] = sum over i of a[i]*W[i][j].
- Sits between the activation buffer and the accumulator/writeback stage.

---
 rtl/systolic_array_ws_if.sv | 28 ++
 rtl/systolic_array_ws.sv | 173 +++++++++++++++++
 tb/tb_systolic_array_ws.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_ws_if.sv
// Handshake bundle for the weight-stationary systolic array: weight beats, activation
// vectors, result vectors and the busy flag.
interface systolic_array_ws_if #(
    parameter int unsigned ROWS   = 2,
    parameter int unsigned COLS   = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24
);
    logic                     w_valid;
    logic [COLS*DATA_W-1:0]   w_data;
    logic                     w_ready;
    logic                     a_valid;
    logic [ROWS*DATA_W-1:0]   a_data;
    logic                     a_ready;
    logic                     out_valid;
    logic [COLS*ACC_W-1:0]    out_data;
    logic                     busy;

    modport master (
        output w_valid, w_data, a_valid, a_data,
        input  w_ready, a_ready, out_valid, out_data, busy
    );

    modport slave (
        input  w_valid, w_data, a_valid, a_data,
        output w_ready, a_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/systolic_array_ws.sv
// ROWS x COLS weight-stationary systolic array: weight-load sequencer, input skew,
// MAC grid with downward partial sums, output de-skew and a registered result vector.
module systolic_array_ws #(
    parameter int unsigned ROWS   = 2,
    parameter int unsigned COLS   = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned SIGNED = 0
) (
    input  logic               clk,
    input  logic               reset,
    systolic_array_ws_if.slave bus
);
    localparam int unsigned LAT = ROWS + COLS - 1;
    localparam int unsigned RCW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned IFW = $clog2(ROWS + COLS + 1);
    localparam int unsigned MW  = (ACC_W > 2 * DATA_W) ? ACC_W : 2 * DATA_W;

    typedef enum logic [1:0] {StIdle, StLoadW, StStream, StDrain} state_e;

    state_e                state_q, state_d;
    logic [RCW-1:0]        row_cnt_q, row_cnt_d;
    logic [IFW-1:0]        inflight_q, inflight_d;
    logic [DATA_W-1:0]     w_q   [ROWS][COLS];
    logic [DATA_W-1:0]     w_d   [ROWS][COLS];
    logic [DATA_W-1:0]     sk_q  [ROWS][ROWS];
    logic [DATA_W-1:0]     sk_d  [ROWS][ROWS];
    logic [DATA_W-1:0]     act_q [ROWS][COLS];
    logic [DATA_W-1:0]     act_d [ROWS][COLS];
    logic [ACC_W-1:0]      ps_q  [ROWS][COLS];
    logic [ACC_W-1:0]      ps_d  [ROWS][COLS];
    logic [ACC_W-1:0]      ds_q  [COLS][COLS];
    logic [ACC_W-1:0]      ds_d  [COLS][COLS];
    logic [LAT-1:0]        v_q, v_d;
    logic                  out_valid_q, out_valid_d;
    logic [COLS*ACC_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0]     a_in   [ROWS];
    logic [DATA_W-1:0]     a_left [ROWS][COLS];
    logic                  w_acc, a_acc;

    function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] w);
        logic [2*DATA_W-1:0] p;
        logic [MW-1:0]       e;
        if (SIGNED != 0) begin
            p = (2 * DATA_W)'($signed(a)) * (2 * DATA_W)'($signed(w));
            e = MW'($signed(p));
        end else begin
            p = (2 * DATA_W)'(a) * (2 * DATA_W)'(w);
            e = MW'(p);
        end
        return e[ACC_W-1:0];
    endfunction

    assign w_acc = bus.w_valid & bus.w_ready;
    assign a_acc = bus.a_valid & bus.a_ready;

    // w_ready is gated by reset so nothing looks acceptable while reset is held.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        bus.w_ready = 1'b0;
        bus.a_ready = 1'b0;
        unique case (state_q)
            StIdle, StLoadW: begin
                bus.w_ready = reset;
                if (bus.w_valid) begin
                    if (row_cnt_q == RCW'(ROWS - 1)) begin
                        state_d   = StStream;
                        row_cnt_d = '0;
                    end else begin
                        state_d   = StLoadW;
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            StStream: begin
                bus.a_ready = 1'b1;
                if (bus.w_valid && !bus.a_valid) state_d = StDrain;
            end
            StDrain: begin
                if (inflight_q == '0) begin
                    state_d   = StLoadW;
                    row_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        w_d = w_q;
        if (w_acc) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                w_d[row_cnt_q][c] = bus.w_data[c*DATA_W +: DATA_W];
            end
        end
        // Non-accepted cycles feed zeros so bubbles carry no stale activations.
        for (int unsigned r = 0; r < ROWS; r++) begin
            a_in[r] = a_acc ? bus.a_data[r*DATA_W +: DATA_W] : '0;
            for (int unsigned k = 0; k < ROWS; k++) begin
                if (k == 0) sk_d[r][k] = a_in[r];
                else        sk_d[r][k] = sk_q[r][k-1];
            end
        end
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (c != 0)      a_left[r][c] = act_q[r][c-1];
                else if (r == 0) a_left[r][c] = a_in[0];
                else             a_left[r][c] = sk_q[r][r-1];
                act_d[r][c] = a_left[r][c];
                if (r == 0) ps_d[r][c] = mul_ext(a_left[r][c], w_q[r][c]);
                else        ps_d[r][c] = ps_q[r-1][c] + mul_ext(a_left[r][c], w_q[r][c]);
            end
        end
    end

    always_comb begin
        for (int unsigned c = 0; c < COLS; c++) begin
            for (int unsigned k = 0; k < COLS; k++) begin
                if (k == 0) ds_d[c][k] = ps_q[ROWS-1][c];
                else        ds_d[c][k] = ds_q[c][k-1];
            end
        end
        v_d[0] = a_acc;
        for (int unsigned k = 1; k < LAT; k++) v_d[k] = v_q[k-1];
        out_valid_d = v_q[LAT-1];
        out_data_d  = out_data_q;
        if (v_q[LAT-1]) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (c == COLS - 1) out_data_d[c*ACC_W +: ACC_W] = ps_q[ROWS-1][c];
                else               out_data_d[c*ACC_W +: ACC_W] = ds_q[c][COLS-2-c];
            end
        end
        unique case ({a_acc, out_valid_q})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            row_cnt_q   <= '0;
            inflight_q  <= '0;
            w_q         <= '{default: '0};
            sk_q        <= '{default: '0};
            act_q       <= '{default: '0};
            ps_q        <= '{default: '0};
            ds_q        <= '{default: '0};
            v_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            inflight_q  <= inflight_d;
            w_q         <= w_d;
            sk_q        <= sk_d;
            act_q       <= act_d;
            ps_q        <= ps_d;
            ds_q        <= ds_d;
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q == StLoadW) || (state_q == StDrain) || (inflight_q != '0);
endmodule

// File: tb/tb_systolic_array_ws.sv
// Bench for systolic_array_ws: a 2x2 unsigned and a 4x3 signed instance, both ACC_W=16,
// checked against a dot-product reference with a cycle-stamped expectation queue.
module tb_systolic_array_ws;
    localparam int LAT_A = 3;
    localparam int LAT_B = 6;

    typedef struct {
        int          due;
        logic [47:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a_n;
    logic rst_b_n;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t       qa[$];
    exp_t       qb[$];
    exp_t       ea, eb;
    logic [7:0] wm_a [4][3];
    logic [7:0] wm_b [4][3];
    logic [7:0] act_a [4];
    logic [7:0] act_b [4];
    int         wa_row, wb_row;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_array_ws_if #(.ROWS(2), .COLS(2), .DATA_W(8), .ACC_W(16)) ia ();
    systolic_array_ws_if #(.ROWS(4), .COLS(3), .DATA_W(8), .ACC_W(16)) ib ();

    systolic_array_ws #(.ROWS(2), .COLS(2), .DATA_W(8), .ACC_W(16), .SIGNED(0)) dut_a (
        .clk  (clk),
        .reset(rst_a_n),
        .bus  (ia)
    );

    systolic_array_ws #(.ROWS(4), .COLS(3), .DATA_W(8), .ACC_W(16), .SIGNED(1)) dut_b (
        .clk  (clk),
        .reset(rst_b_n),
        .bus  (ib)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // out[j] = sum_i a[i]*W[i][j], modulo 2^16.
    function automatic logic [47:0] ref_vec(input int rows, input int cols, input bit sgn,
                                            input logic [7:0] act [4],
                                            input logic [7:0] w [4][3]);
        logic [47:0] r;
        int          s, ai, wi;
        r = '0;
        for (int j = 0; j < cols; j++) begin
            s = 0;
            for (int i = 0; i < rows; i++) begin
                ai = sgn ? int'($signed(act[i])) : int'(act[i]);
                wi = sgn ? int'($signed(w[i][j])) : int'(w[i][j]);
                s += ai * wi;
            end
            r[16*j +: 16] = s[15:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_a_n) begin
            qa.delete();
            wa_row = 0;
            wm_a   = '{default: '0};
        end else begin
            if (qa.size() != 0 && qa[0].due == cyc) begin
                ea = qa.pop_front();
                check("a_out_valid", 64'(ia.out_valid), 64'd1);
                check("a_out_data", 64'(ia.out_data), 64'(ea.v[31:0]));
            end else if (ia.out_valid) begin
                check("a_stray_valid", 64'(ia.out_valid), 64'd0);
            end
            if (ia.w_valid && ia.w_ready) begin
                for (int j = 0; j < 2; j++) wm_a[wa_row][j] = ia.w_data[8*j +: 8];
                wa_row = (wa_row + 1) % 2;
            end
            if (ia.a_valid && ia.a_ready) begin
                act_a = '{default: '0};
                for (int i = 0; i < 2; i++) act_a[i] = ia.a_data[8*i +: 8];
                qa.push_back('{due: cyc + 1 + LAT_A, v: ref_vec(2, 2, 1'b0, act_a, wm_a)});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b_n) begin
            qb.delete();
            wb_row = 0;
            wm_b   = '{default: '0};
        end else begin
            if (qb.size() != 0 && qb[0].due == cyc) begin
                eb = qb.pop_front();
                check("b_out_valid", 64'(ib.out_valid), 64'd1);
                check("b_out_data", 64'(ib.out_data), 64'(eb.v));
            end else if (ib.out_valid) begin
                check("b_stray_valid", 64'(ib.out_valid), 64'd0);
            end
            if (ib.w_valid && ib.w_ready) begin
                for (int j = 0; j < 3; j++) wm_b[wb_row][j] = ib.w_data[8*j +: 8];
                wb_row = (wb_row + 1) % 4;
            end
            if (ib.a_valid && ib.a_ready) begin
                for (int i = 0; i < 4; i++) act_b[i] = ib.a_data[8*i +: 8];
                qb.push_back('{due: cyc + 1 + LAT_B, v: ref_vec(4, 3, 1'b1, act_b, wm_b)});
            end
        end
    end

    task automatic send_w(input bit b, input logic [31:0] d);
        int n = 0;
        if (b) begin ib.w_valid = 1'b1; ib.w_data = d[23:0]; end
        else   begin ia.w_valid = 1'b1; ia.w_data = d[15:0]; end
        @(negedge clk);
        while (!(b ? ib.w_ready : ia.w_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("w_accept_bound", 64'(n < 100), 64'd1);
        @(posedge clk); #1;
        if (b) ib.w_valid = 1'b0; else ia.w_valid = 1'b0;
    endtask

    task automatic send_a(input bit b, input logic [31:0] d);
        int n = 0;
        if (b) begin ib.a_valid = 1'b1; ib.a_data = d; end
        else   begin ia.a_valid = 1'b1; ia.a_data = d[15:0]; end
        @(negedge clk);
        while (!(b ? ib.a_ready : ia.a_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("a_accept_bound", 64'(n < 100), 64'd1);
        @(posedge clk); #1;
        if (b) ib.a_valid = 1'b0; else ia.a_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle(input bit b);
        int n = 0;
        @(negedge clk);
        while ((b ? ib.busy : ia.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_bound", 64'(n < 200), 64'd1);
        @(posedge clk); #1;
    endtask

    // Counts negedges after an accept until out_valid is seen.
    task automatic wait_out(input bit b, output int n);
        n = 0;
        @(negedge clk);
        while (!(b ? ib.out_valid : ia.out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        ia.w_valid = 1'b0; ia.w_data = '0; ia.a_valid = 1'b0; ia.a_data = '0;
        ib.w_valid = 1'b0; ib.w_data = '0; ib.a_valid = 1'b0; ib.a_data = '0;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        #1 rst_a_n = 1'b0; rst_b_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(ia.out_valid), 64'd0);
        check("rst_out_data", 64'(ia.out_data), 64'd0);
        check("rst_a_ready", 64'(ia.a_ready), 64'd0);
        check("rst_w_ready", 64'(ia.w_ready), 64'd0);
        check("rst_busy", 64'(ia.busy), 64'd0);
        check("rst_b_w_ready", 64'(ib.w_ready), 64'd0);
        @(posedge clk); #3;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        #1;
        check("idle_w_ready", 64'(ia.w_ready), 64'd1);
        check("idle_a_ready", 64'(ia.a_ready), 64'd0);
        @(posedge clk); #1;

        // Basic 2x2, back-to-back
        send_w(1'b0, {8'd10, 8'd4});
        send_w(1'b0, {8'd6, 8'd9});
        send_a(1'b0, {8'd7, 8'd2});
        send_a(1'b0, {8'd1, 8'd3});
        repeat (4) @(negedge clk);
        check("t1_second_valid", 64'(ia.out_valid), 64'd1);
        check("t1_second_data", 64'(ia.out_data), 64'({16'd36, 16'd21}));
        check("t1_busy_last", 64'(ia.busy), 64'd1);
        @(negedge clk);
        check("t1_valid_pulse", 64'(ia.out_valid), 64'd0);
        check("t1_busy_fall", 64'(ia.busy), 64'd0);
        check("t1_data_hold", 64'(ia.out_data), 64'({16'd36, 16'd21}));
        @(posedge clk); #1;

        // Bubble between vectors
        send_a(1'b0, {8'd7, 8'd2});
        idle(1);
        send_a(1'b0, {8'd1, 8'd3});
        wait_idle(1'b0);

        // Reload with drain: activation wins over a simultaneous weight beat
        ia.a_valid = 1'b1; ia.a_data = {8'd7, 8'd2};
        ia.w_valid = 1'b1; ia.w_data = {8'd0, 8'd1};
        @(negedge clk);
        check("t4_a_ready_stream", 64'(ia.a_ready), 64'd1);
        check("t4_w_ready_stream", 64'(ia.w_ready), 64'd0);
        @(posedge clk); #1;
        ia.a_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4_a_ready_drain", 64'(ia.a_ready), 64'd0);
        check("t4_w_ready_drain", 64'(ia.w_ready), 64'd0);
        check("t4_busy_drain", 64'(ia.busy), 64'd1);
        n = 0;
        while (!ia.w_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_w_ready_bound", 64'(n < 50), 64'd1);
        check("t4_old_result_first", 64'(qa.size()), 64'd0);
        @(posedge clk); #1;
        ia.w_valid = 1'b0;
        send_w(1'b0, {8'd1, 8'd0});
        send_a(1'b0, {8'd6, 8'd5});
        wait_out(1'b0, n);
        check("t4_new_latency", 64'(n), 64'd3);
        check("t4_new_data", 64'(ia.out_data), 64'({16'd6, 16'd5}));
        @(posedge clk); #1;
        wait_idle(1'b0);

        // Unsigned wrap
        send_w(1'b0, 32'h0000_FFFF);
        send_w(1'b0, 32'h0000_FFFF);
        send_a(1'b0, 32'h0000_FFFF);
        wait_out(1'b0, n);
        check("t3a_latency", 64'(n), 64'd3);
        check("t3a_data", 64'(ia.out_data), 64'({16'd64514, 16'd64514}));
        @(posedge clk); #1;
        wait_idle(1'b0);

        // Randomised traffic on the 2x2 instance
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 2; k++) send_w(1'b0, $urandom);
            for (int k = 0; k < 12; k++) begin
                send_a(1'b0, $urandom);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            wait_idle(1'b0);
        end

        // Reset mid-stream discards the in-flight result
        send_a(1'b0, {8'd7, 8'd2});
        @(posedge clk); #2;
        rst_a_n = 1'b0;
        #1;
        check("t5_out_valid_async", 64'(ia.out_valid), 64'd0);
        check("t5_busy_async", 64'(ia.busy), 64'd0);
        check("t5_w_ready_in_rst", 64'(ia.w_ready), 64'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        rst_a_n = 1'b1;
        #1;
        check("t5_w_ready_rel", 64'(ia.w_ready), 64'd1);
        check("t5_a_ready_rel", 64'(ia.a_ready), 64'd0);
        check("t5_busy_rel", 64'(ia.busy), 64'd0);
        @(posedge clk); #1;
        idle(6);

        // 4x3 identity-like weights, latency 6
        send_w(1'b1, 32'h00_0001);
        send_w(1'b1, 32'h00_0100);
        send_w(1'b1, 32'h01_0000);
        send_w(1'b1, 32'h00_0000);
        send_a(1'b1, {8'd4, 8'd3, 8'd2, 8'd1});
        wait_out(1'b1, n);
        check("t6_latency", 64'(n), 64'd6);
        check("t6_data", 64'(ib.out_data), 64'({16'd3, 16'd2, 16'd1}));
        @(posedge clk); #1;
        wait_idle(1'b1);

        // Signed: all weights -1, a=(3,5,0,0)
        for (int k = 0; k < 4; k++) send_w(1'b1, 32'h00FF_FFFF);
        send_a(1'b1, {8'd0, 8'd0, 8'd5, 8'd3});
        wait_out(1'b1, n);
        check("t3b_latency", 64'(n), 64'd6);
        check("t3b_data", 64'(ib.out_data), 64'h0000_FFF8_FFF8_FFF8);
        @(posedge clk); #1;
        wait_idle(1'b1);

        // Randomised traffic on the signed 4x3 instance
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) send_w(1'b1, $urandom);
            for (int k = 0; k < 10; k++) begin
                send_a(1'b1, $urandom);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            wait_idle(1'b1);
        end
        check("b_queue_empty", 64'(qb.size()), 64'd0);
        check("a_queue_empty", 64'(qa.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
